lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit between pipeline MEM stage and byte-addressed `ram`. Takes one
//  request at a time over valid/ready, classifies faults, drives ram load/store/access/addr/data_in.
//  Holds 1-cycle ram read result; returns completion over valid/ready with backpressure.
//  `ram` has no alignment/range handling; this block guarantees it only sees legal accesses.
// PARAMETERS
//  ADDR_WIDTH  11  ram byte-address bits; legal range 0 .. 2**ADDR_WIDTH-1
// PORTS
//  clk           in   1   single clock, posedge
//  rst           in   1   synchronous, active-high reset (same rst as ram)
//  req_valid     in   1   request present
//  req_ready     out  1   1 only in IDLE and rst=0
//  req_store     in   1   1=store, 0=load
//  req_funct3    in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, low-aligned (SB uses [7:0], SH [15:0])
//  req_rd        in   5   destination tag, echoed
//  resp_valid    out  1   completion present
//  resp_ready    in   1   consumer accepts completion
//  resp_data     out  32  load result (already extended by ram); 0 for store/fault
//  resp_rd       out  5   echoed req_rd
//  resp_fault    out  2   00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3
//  resp_badaddr  out  32  req_addr when resp_fault!=0, else 0
//  ram_load      out  1   to ram.load
//  ram_store     out  1   to ram.store
//  ram_access    out  3   to ram.access
//  ram_addr      out  32  to ram.addr
//  ram_wdata     out  32  to ram.data_in
//  ram_rdata     in   32  from ram.data_out
// BEHAVIOUR
//  Reset: state IDLE; resp_valid=0, resp_data=0, resp_rd=0, resp_fault=0, resp_badaddr=0;
//   ram_load=ram_store=0 while rst=1. In-flight request dropped, no response emitted.
//  Accept: edge where req_valid&&req_ready. ram_* driven combinationally from req_* in
//   accept cycle only; ram_load/ram_store=1 only if accepted and fault-free; else 0.
//  Fault classify (priority high->low): illegal funct3 (load 011/110/111; store any
//   funct3 not 000/001/010) > misaligned (H/HU/SH addr[0]!=0; W/SW addr[1:0]!=0)
//   > out-of-range (req_addr[31:ADDR_WIDTH]!=0). Faulting request never touches ram.
//  FSM: IDLE -accept load ok-> RDWAIT -> RESP (latch resp_data<=ram_rdata)
//       IDLE -accept store ok or any fault-> RESP (resp_data=0)
//       RESP -resp_ready-> IDLE;  RESP holds all resp_* stable while resp_ready=0.
//  Latency (accept edge E0): store/fault resp_valid high after E0; load after E1.
//  Throughput: one request per 2 cycles (store) / 3 cycles (load) with resp_ready=1.
//  No req accepted while RDWAIT/RESP (req_ready=0); no same-cycle handoff RESP->accept.
//  ram_rdata only sampled in RDWAIT; its value outside that cycle ignored.
//  Address passed to ram unmodified; ram uses low ADDR_WIDTH bits.
// STRUCTURE
//  lsu_pkg: funct3 constants (F3_B,F3_H,F3_W,F3_BU,F3_HU), fault codes
//   (FLT_NONE,FLT_MISALIGN,FLT_RANGE,FLT_ILLEGAL), state enum (IDLE,RDWAIT,RESP).
//  Sub-module lsu_fault_chk: combinational {store,funct3,addr} -> fault[1:0].
//  Top: FSM + response registers + ram port muxing.
// TESTING (bench instantiates lsu + ram, shared clk/rst)
//  SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> store ack fault=00 data=0; load
//   resp_data=0xDEADBEEF exactly 2 cycles after accept.
//  After above, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD;
//   LHU 0x10 -> 0x0000BEEF.
//  LW 0x11 -> fault=01, badaddr=0x11, ram_load never 1; SH 0x3 -> fault=01, mem unchanged.
//  LW 0x800 (ADDR_WIDTH=11) -> fault=10; funct3=011 load -> fault=11; SW funct3=100 -> fault=11.
//  Hold resp_ready=0 for 5 cycles on a load -> resp_* stable, req_ready=0; issue new
//   req_valid meanwhile -> not accepted until cycle after resp handshake.
//  Assert rst in RDWAIT -> next cycle resp_valid=0, state IDLE, no response ever emitted.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: access widths,
// fault codes and the request-tracking FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10,
        FLT_ILLEGAL  = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RDWAIT = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/lsu_fault_chk.sv
// Combinational fault classifier for one memory request. Priority is
// illegal funct3, then misalignment, then address beyond the ram.
module lsu_fault_chk
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    output fault_e      fault_o
);

    logic illegal;
    logic misalign;
    logic out_of_range;

    // Stores have no unsigned variants, so BU/HU encodings are illegal for them.
    assign illegal = store_i ? !(funct3_i inside {F3_B, F3_H, F3_W})
                             : !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    assign out_of_range = (addr_i >> ADDR_WIDTH) != '0;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        misalign = 1'b0;
        fault_o  = FLT_NONE;
        case (funct3_i)
            F3_H, F3_HU: misalign = addr_i[0];
            F3_W:        misalign = |addr_i[1:0];
            default:     misalign = 1'b0;
        endcase
        if (illegal)           fault_o = FLT_ILLEGAL;
        else if (misalign)     fault_o = FLT_MISALIGN;
        else if (out_of_range) fault_o = FLT_RANGE;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one MEM-stage request at a time, screens it for
// faults, drives the byte-addressed ram and returns a registered completion.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic [1:0]  resp_fault,
    output logic [31:0] resp_badaddr,
    output logic        ram_load,
    output logic        ram_store,
    output logic [2:0]  ram_access,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_e      state_q;
    fault_e      fault;
    logic        accept;
    logic        clean;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic [4:0]  resp_rd_q;
    logic [1:0]  resp_fault_q;
    logic [31:0] resp_badaddr_q;

    lsu_fault_chk #(.ADDR_WIDTH(ADDR_WIDTH)) u_fault_chk (
        .store_i  (req_store),
        .funct3_i (req_funct3),
        .addr_i   (req_addr),
        .fault_o  (fault)
    );

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign clean     = accept && (fault == FLT_NONE);

    // The ram sees the request only in its accept cycle and only when it is legal.
    assign ram_load   = clean && !req_store;
    assign ram_store  = clean && req_store;
    assign ram_access = accept ? req_funct3 : '0;
    assign ram_addr   = accept ? req_addr   : '0;
    assign ram_wdata  = accept ? req_wdata  : '0;

    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_rd      = resp_rd_q;
    assign resp_fault   = resp_fault_q;
    assign resp_badaddr = resp_badaddr_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q        <= IDLE;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_rd_q      <= '0;
            resp_fault_q   <= FLT_NONE;
            resp_badaddr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        resp_rd_q      <= req_rd;
                        resp_fault_q   <= fault;
                        resp_badaddr_q <= (fault != FLT_NONE) ? req_addr : '0;
                        resp_data_q    <= '0;
                        if (clean && !req_store) begin
                            state_q <= RDWAIT;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end
                    end
                end
                RDWAIT: begin
                    // The ram returns load data exactly one cycle after ram_load.
                    resp_data_q  <= ram_rdata;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu with a behavioural byte-addressed ram alongside it; responses
// are checked against a byte-array reference model of the memory.
module tb_lsu;

    localparam int AW       = 11;
    localparam int MEM_SIZE = 1 << AW;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_fault;
    logic [31:0] resp_badaddr;
    logic        ram_load;
    logic        ram_store;
    logic [2:0]  ram_access;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_clear;

    int n_cmp = 0;
    int n_mis = 0;

    lsu #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_rd      (resp_rd),
        .resp_fault   (resp_fault),
        .resp_badaddr (resp_badaddr),
        .ram_load     (ram_load),
        .ram_store    (ram_store),
        .ram_access   (ram_access),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ram: registered, extended read one cycle after load; byte writes.
    logic [7:0] ram_mem [0:MEM_SIZE-1];

    function automatic logic [31:0] ram_read(input logic [2:0] acc, input int a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ram_mem[a % MEM_SIZE];
        b1 = ram_mem[(a + 1) % MEM_SIZE];
        b2 = ram_mem[(a + 2) % MEM_SIZE];
        b3 = ram_mem[(a + 3) % MEM_SIZE];
        case (acc)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < MEM_SIZE; i++) ram_mem[i] <= 8'h00;
        end else if (ram_store) begin
            for (int i = 0; i < (1 << ram_access[1:0]); i++)
                ram_mem[(int'(ram_addr[AW-1:0]) + i) % MEM_SIZE] <= ram_wdata[8*i +: 8];
        end
        if (rst) ram_rdata <= 32'h0;
        else if (ram_load) ram_rdata <= ram_read(ram_access, int'(ram_addr[AW-1:0]));
    end

    // Reference model: a plain byte array updated by the rules of each access.
    logic [7:0] ref_mem [0:MEM_SIZE-1];

    function automatic logic [1:0] model_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int sz;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz    = 1 << f3[1:0];
        if (!legal) return 2'd3;
        if ((a % sz) != 0) return 2'd1;
        if (a >= MEM_SIZE) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        int sz;
        sz = 1 << f3[1:0];
        v  = 0;
        for (int i = 0; i < sz; i++) v += longint'(ref_mem[a + i]) << (8 * i);
        if (!f3[2] && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One full transaction: drive, check the ram port in the accept cycle, wait
    // for the completion, optionally stall it (and poke a request meanwhile), release it.
    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int stall, input bit poke,
                          output logic [31:0] got);
        logic [1:0]  ef;
        logic [31:0] ed;
        logic [31:0] eb;
        logic [4:0]  rd;
        int          n;
        rd = 5'($urandom);
        ef = model_fault(st, f3, a);
        ed = (ef == 2'd0 && !st) ? model_load(f3, a) : 32'h0;
        eb = (ef != 2'd0) ? a : 32'h0;
        if (ef == 2'd0 && st) model_store(f3, a, wd);

        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        resp_ready = (stall == 0);
        #1;
        check("req_ready_idle", req_ready, 1);
        check("ram_load", ram_load, (ef == 2'd0 && !st));
        check("ram_store", ram_store, (ef == 2'd0 && st));
        if (ef == 2'd0) check("ram_addr", ram_addr, a);
        if (ef == 2'd0 && st) check("ram_wdata", ram_wdata, wd);
        @(posedge clk);
        #1 req_valid = 1'b0;

        for (n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) break;
        end
        check("latency", n, (ef == 2'd0 && !st) ? 2 : 1);
        check("resp_data", resp_data, ed);
        check("resp_rd", resp_rd, rd);
        check("resp_fault", resp_fault, ef);
        check("resp_badaddr", resp_badaddr, eb);
        got = resp_data;

        if (stall > 0 && poke) begin
            req_valid  = 1'b1;
            req_store  = 1'b1;
            req_funct3 = 3'b010;
            req_addr   = 32'h20;
            req_wdata  = 32'hBAD0BAD0;
        end
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            #1;
            check("hold_valid", resp_valid, 1);
            check("hold_data", resp_data, ed);
            check("hold_rd", resp_rd, rd);
            check("hold_fault", resp_fault, ef);
            check("hold_badaddr", resp_badaddr, eb);
            check("hold_req_ready", req_ready, 0);
            check("hold_ram_store", ram_store, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("resp_released", resp_valid, 0);
        check("req_ready_after", req_ready, 1);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] got;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;

        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'h00;
        rst        = 1'b1;
        ram_clear  = 1'b1;
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'h0;
        req_rd     = 5'd7;
        resp_ready = 1'b1;

        // Reset state, with a request held on the port.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_rd", resp_rd, 0);
        check("rst_resp_fault", resp_fault, 0);
        check("rst_resp_badaddr", resp_badaddr, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_ram_load", ram_load, 0);
        check("rst_ram_store", ram_store, 0);
        rst       = 1'b0;
        ram_clear = 1'b0;
        req_valid = 1'b0;

        // Store then load back, followed by sub-word extensions.
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0, got);
        check("sw_ack_data", got, 32'h0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, got);
        check("lw_10", got, 32'hDEADBEEF);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b0, got);
        check("lb_13", got, 32'hFFFFFFDE);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 0, 1'b0, got);
        check("lbu_13", got, 32'h000000DE);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 0, 1'b0, got);
        check("lh_12", got, 32'hFFFFDEAD);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, 0, 1'b0, got);
        check("lhu_10", got, 32'h0000BEEF);

        // Faults of each class; the faulting store must leave memory intact.
        do_req(1'b0, 3'b010, 32'h11, 32'h0, 0, 1'b0, got);
        do_req(1'b1, 3'b001, 32'h3, 32'h0000FFFF, 0, 1'b0, got);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 0, 1'b0, got);
        check("sh_fault_mem", got, 32'h0);
        do_req(1'b0, 3'b010, 32'h800, 32'h0, 0, 1'b0, got);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b0, got);
        do_req(1'b1, 3'b100, 32'h10, 32'h12345678, 0, 1'b0, got);

        // Backpressure on a load with a competing request that must not be taken.
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, 1'b1, got);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0, got);
        check("poke_not_written", got, 32'h0);

        // Reset while the load waits for ram data: the response is dropped.
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rdwait_no_valid", resp_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rdwait_rst_valid", resp_valid, 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("post_rst_valid", resp_valid, 0);
            check("post_rst_ready", req_ready, 1);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, got);
        check("lw_after_rst", got, 32'hDEADBEEF);

        // Randomised traffic against the reference model.
        for (int t = 0; t < 150; t++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
            do_req(st, f3, a, $urandom, $urandom_range(0, 2), 1'b0, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
